// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point field widths, bias and packing helpers
package fp_pkg;

  localparam int DEF_NB_SIGN = 1;
  localparam int DEF_NB_EXPO = 4;
  localparam int DEF_NB_MANT = 8;
  localparam int DEF_BIAS    = (2**DEF_NB_EXPO - 1) >> 1;
  localparam int DEF_NB_WORD = DEF_NB_SIGN + DEF_NB_EXPO + DEF_NB_MANT;

  typedef struct packed {
    logic [DEF_NB_SIGN-1:0] sign;
    logic [DEF_NB_EXPO-1:0] expo;
    logic [DEF_NB_MANT-1:0] mant;
  } fpWord_t;

  function automatic fpWord_t packFp(logic [DEF_NB_SIGN-1:0] sign,
                                     logic [DEF_NB_EXPO-1:0] expo,
                                     logic [DEF_NB_MANT-1:0] mant);
    fpWord_t w;
    w.sign = sign;
    w.expo = expo;
    w.mant = mant;
    return w;
  endfunction

  function automatic fpWord_t unpackFp(logic [DEF_NB_WORD-1:0] raw);
    return fpWord_t'(raw);
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even on a truncated fraction
module fp_round_rne import fp_pkg::*; #(
  parameter int NB_MANT = DEF_NB_MANT
) (
  input  logic [NB_MANT-1:0] frac,
  input  logic               guard,
  input  logic               sticky,
  output logic [NB_MANT-1:0] fracRnd,
  output logic               carry
);

  logic roundUp;

  // Ties (guard set, nothing below it) round only when that makes the lsb even.
  assign roundUp          = guard & (sticky | frac[0]);
  assign {carry, fracRnd} = {1'b0, frac} + {{NB_MANT{1'b0}}, roundUp};

endmodule

// File: rtl/fp_product_normalizer.sv
// rtl/fp_product_normalizer.sv - 2-stage normalize/round/saturate stage for the fp multiplier
module fp_product_normalizer import fp_pkg::*; #(
  parameter int NB_SIGN = DEF_NB_SIGN,
  parameter int NB_EXPO = DEF_NB_EXPO,
  parameter int NB_MANT = DEF_NB_MANT
) (
  input  logic                              clk,
  input  logic                              i_rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [NB_SIGN-1:0]                i_sign,
  input  logic                              i_zero,
  input  logic [NB_EXPO:0]                  i_exp_sum,
  input  logic [2*(NB_MANT+1)-1:0]          i_mant_prod,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [NB_SIGN+NB_EXPO+NB_MANT-1:0] o_data,
  output logic                              o_ovf,
  output logic                              o_unf
);

  localparam int NB_E = NB_EXPO + 2;
  localparam int BIAS = (2**NB_EXPO - 1) >> 1;
  localparam logic [NB_E-1:0] MAX_E = NB_E'(2**NB_EXPO - 1);

  logic s1En, s2En;

  logic               s1Valid;
  logic [NB_SIGN-1:0] s1Sign;
  logic               s1Zero;
  logic [NB_E-1:0]    s1Exp;
  logic [NB_MANT-1:0] s1Frac;
  logic               s1Guard;
  logic               s1Sticky;

  logic               norm;
  logic [NB_MANT-1:0] fracN;
  logic               guardN;
  logic               stickyN;
  logic [NB_E-1:0]    expN;

  logic [NB_MANT-1:0] fracRnd;
  logic               carry;
  logic [NB_E-1:0]    expRnd;
  logic               unfN;
  logic               ovfN;
  logic [NB_SIGN+NB_EXPO+NB_MANT-1:0] dataN;
  logic               ovfOut;
  logic               unfOut;

  assign s2En    = !o_valid || i_ready;
  assign s1En    = !s1Valid || s2En;
  assign o_ready = s1En;

  // Product lies in [1,4); a set MSB means the leading one sits one place higher.
  always_comb begin
    norm    = i_mant_prod[2*NB_MANT+1];
    fracN   = i_mant_prod[2*NB_MANT-1 -: NB_MANT];
    guardN  = i_mant_prod[NB_MANT-1];
    stickyN = |i_mant_prod[NB_MANT-2:0];
    if (norm) begin
      fracN   = i_mant_prod[2*NB_MANT -: NB_MANT];
      guardN  = i_mant_prod[NB_MANT];
      stickyN = |i_mant_prod[NB_MANT-1:0];
    end
    expN = {1'b0, i_exp_sum} - NB_E'(BIAS) + {{(NB_E-1){1'b0}}, norm};
  end

  fp_round_rne #(.NB_MANT(NB_MANT)) uRound (
    .frac    (s1Frac),
    .guard   (s1Guard),
    .sticky  (s1Sticky),
    .fracRnd (fracRnd),
    .carry   (carry)
  );

  // Limits are judged on the exponent after the rounding carry has been folded in.
  always_comb begin
    expRnd = s1Exp + {{(NB_E-1){1'b0}}, carry};
    unfN   = expRnd[NB_E-1] || (expRnd == '0);
    ovfN   = !expRnd[NB_E-1] && (expRnd > MAX_E);
    dataN  = {s1Sign, expRnd[NB_EXPO-1:0], fracRnd};
    ovfOut = 1'b0;
    unfOut = 1'b0;
    if (s1Zero) begin
      dataN = {s1Sign, {NB_EXPO{1'b0}}, {NB_MANT{1'b0}}};
    end else if (unfN) begin
      dataN  = {s1Sign, {NB_EXPO{1'b0}}, {NB_MANT{1'b0}}};
      unfOut = 1'b1;
    end else if (ovfN) begin
      dataN  = {s1Sign, {NB_EXPO{1'b1}}, {NB_MANT{1'b1}}};
      ovfOut = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      s1Valid  <= 1'b0;
      s1Sign   <= '0;
      s1Zero   <= 1'b0;
      s1Exp    <= '0;
      s1Frac   <= '0;
      s1Guard  <= 1'b0;
      s1Sticky <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_ovf    <= 1'b0;
      o_unf    <= 1'b0;
    end else begin
      if (s1En) begin
        s1Valid <= i_valid;
        if (i_valid) begin
          s1Sign   <= i_sign;
          s1Zero   <= i_zero;
          s1Exp    <= expN;
          s1Frac   <= fracN;
          s1Guard  <= guardN;
          s1Sticky <= stickyN;
        end
      end
      if (s2En) begin
        o_valid <= s1Valid;
        if (s1Valid) begin
          o_data <= dataN;
          o_ovf  <= ovfOut;
          o_unf  <= unfOut;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_product_normalizer.sv
// tb/tb_fp_product_normalizer.sv - scoreboard bench for fp_product_normalizer
module tb_fp_product_normalizer;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [0:0]  i_sign;
  logic        i_zero;
  logic [4:0]  i_exp_sum;
  logic [17:0] i_mant_prod;
  logic        o_valid;
  logic        i_ready;
  logic [12:0] o_data;
  logic        o_ovf;
  logic        o_unf;

  always #5 clk = ~clk;

  fp_product_normalizer dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sign      (i_sign),
    .i_zero      (i_zero),
    .i_exp_sum   (i_exp_sum),
    .i_mant_prod (i_mant_prod),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_ovf       (o_ovf),
    .o_unf       (o_unf)
  );

  typedef struct {
    logic [12:0] data;
    logic        ovf;
    logic        unf;
  } expect_t;

  expect_t sbq[$];
  int      compared   = 0;
  int      mismatched = 0;
  bit      readyRandom = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: treat the product as an integer, divide down to NB_MANT+1 significant
  // bits, round half-to-even on the remainder, then apply the exponent limits.
  function automatic expect_t model(logic s, logic z, int expSum, int prod);
    expect_t r;
    int norm, sh, q, rem, half, e;
    norm = (prod >= (1 << 17)) ? 1 : 0;
    sh   = DEF_NB_MANT + norm;
    q    = prod >> sh;
    rem  = prod - (q << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    e = expSum - DEF_BIAS + norm;
    if (q >= (1 << (DEF_NB_MANT + 1))) begin
      q = q >> 1;
      e++;
    end
    r.ovf = 1'b0;
    r.unf = 1'b0;
    if (z) r.data = packFp(s, 4'h0, 8'h00);
    else if (e <= 0) begin
      r.data = packFp(s, 4'h0, 8'h00);
      r.unf  = 1'b1;
    end else if (e > 15) begin
      r.data = packFp(s, 4'hF, 8'hFF);
      r.ovf  = 1'b1;
    end else r.data = packFp(s, e[3:0], q[7:0]);
    return r;
  endfunction

  task automatic sendBeat(logic s, logic z, logic [4:0] es, logic [17:0] mp, expect_t ex);
    int  n = 0;
    bit  done = 1'b0;
    i_valid     = 1'b1;
    i_sign      = s;
    i_zero      = z;
    i_exp_sum   = es;
    i_mant_prod = mp;
    while (!done) begin
      @(negedge clk);
      if (o_ready) done = 1'b1;
      else begin
        n++;
        if (n > 200) begin
          compared++;
          mismatched++;
          $display("FAIL accept_timeout: got o_ready=0 for %0d cycles expected 1", n);
          done = 1'b1;
        end
      end
    end
    if (n <= 200) sbq.push_back(ex);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic sendRandom();
    logic        s, z;
    logic [4:0]  es;
    logic [17:0] mp;
    int          a, b;
    s  = 1'($urandom_range(0, 1));
    z  = ($urandom_range(0, 7) == 0);
    es = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 1) == 1) begin
      a  = $urandom_range(256, 511);
      b  = $urandom_range(256, 511);
      mp = 18'(a * b);
    end else mp = 18'($urandom_range(1 << 16, (1 << 18) - 1));
    sendBeat(s, z, es, mp, model(s, z, int'(es), int'(mp)));
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", sbq.size());
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  logic        prevStall = 1'b0;
  logic [12:0] prevData;
  logic [1:0]  prevFlags;
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (i_rst) prevStall = 1'b0;
      else begin
        if (prevStall) begin
          check("hold_valid", 32'(o_valid), 32'd1);
          check("hold_data", 32'(o_data), 32'(prevData));
          check("hold_flags", 32'({o_ovf, o_unf}), 32'(prevFlags));
        end
        if (o_valid && i_ready) begin
          if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_beat: got %0h expected no beat", o_data);
          end else begin
            e = sbq.pop_front();
            check("data", 32'(o_data), 32'(e.data));
            check("ovf", 32'(o_ovf), 32'(e.ovf));
            check("unf", 32'(o_unf), 32'(e.unf));
          end
        end
        prevStall = o_valid && !i_ready;
        prevData  = o_data;
        prevFlags = {o_ovf, o_unf};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (readyRandom) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_sign = 1'b0; i_zero = 1'b0;
    i_exp_sum = '0; i_mant_prod = '0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
    check("rst_unf", 32'(o_unf), 32'd0);
    i_rst = 1'b0;
    check("rst_ready", 32'(o_ready), 32'd1);

    sendBeat(1'b0, 1'b0, 5'd14, 18'h24000, '{13'h0820, 1'b0, 1'b0});
    check("lat_not_yet", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(o_valid), 32'd1);
    check("lat_data", 32'(o_data), 32'h0820);

    sendBeat(1'b0, 1'b0, 5'd14, 18'h18180, '{13'h0782, 1'b0, 1'b0});
    sendBeat(1'b0, 1'b0, 5'd14, 18'h10080, '{13'h0700, 1'b0, 1'b0});
    sendBeat(1'b0, 1'b0, 5'd14, 18'h20301, '{13'h0802, 1'b0, 1'b0});
    sendBeat(1'b0, 1'b0, 5'd30, 18'h10000, '{13'h0FFF, 1'b1, 1'b0});
    sendBeat(1'b1, 1'b0, 5'd2,  18'h10000, '{13'h1000, 1'b0, 1'b1});
    sendBeat(1'b0, 1'b1, 5'd30, 18'h3FFFF, '{13'h0000, 1'b0, 1'b0});
    sendBeat(1'b1, 1'b1, 5'd2,  18'h10000, '{13'h1000, 1'b0, 1'b0});
    sendBeat(1'b0, 1'b0, 5'd14, 18'h1FF80, '{13'h0800, 1'b0, 1'b0});
    sendBeat(1'b0, 1'b0, 5'd22, 18'h1FF80, '{13'h0FFF, 1'b1, 1'b0});
    sendBeat(1'b0, 1'b0, 5'd7,  18'h1FF80, '{13'h0100, 1'b0, 1'b0});
    sendBeat(1'b0, 1'b0, 5'd7,  18'h10000, '{13'h0000, 1'b0, 1'b1});
    sendBeat(1'b0, 1'b0, 5'd6,  18'h20000, '{13'h0000, 1'b0, 1'b1});
    sendBeat(1'b0, 1'b0, 5'd21, 18'h10000, '{13'h0E00, 1'b0, 1'b0});
    waitDrain();

    @(posedge clk);
    #1;
    i_ready = 1'b0;
    fork
      begin
        repeat (4) sendRandom();
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_ready_low", 32'(o_ready), 32'd0);
        check("bp_valid_high", 32'(o_valid), 32'd1);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    waitDrain();

    @(posedge clk);
    #1;
    i_ready = 1'b0;
    sendRandom();
    sendRandom();
    #1;
    i_rst = 1'b1;
    #1;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_data", 32'(o_data), 32'd0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    i_rst   = 1'b0;
    i_ready = 1'b1;
    check("postrst_ready", 32'(o_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("postrst_valid", 32'(o_valid), 32'd0);

    @(posedge clk);
    #1;
    readyRandom = 1'b1;
    repeat (300) sendRandom();
    readyRandom = 1'b0;
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    waitDrain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
